slant_lane_tx: RTL and testbench
================================

// Module: slant_lane_tx
// PURPOSE
//  Single-lane symbol transmitter for the slant camera link: frames a 5-bit Y/C pixel stream into
//  6-bit link symbols (frame header, line header, payload) that the receive-side lane decoder
//  parses into its Y/C sample memories. Sits on the camera side, one instance per lane
//  (lanes 0..3), between the pixel packer and the lane pad driver.
// PARAMETERS
//  FRAME1     24'haab155  odd-frame header, sent MSB-first as 4 symbols: 2A,2B,05,15
//  FRAME0     24'haa8d55  even-frame header, sent MSB-first as 4 symbols: 2A,28,35,15
//  HSYNC      8'h55       line-header code; HSYNC[5:0] (=6'h15) is sent twice per line
//  LINE_PIX   160         pixels per line
//  LINES      240         lines per frame (LINE_PIX*LINES = 38400 = receiver memory depth)
//  LINE_GAP   4           idle symbols after each line payload
//  FRAME_GAP  16          idle symbols after the last line, before the next frame header
// PORTS
//  clk          in   1   symbol clock (one symbol per cycle)
//  rstn         in   1   asynchronous active-low reset
//  en           in   1   run enable; sampled only in IDLE and at frame end
//  pix_valid    in   1   pixel available
//  pix_ready    out  1   pixel accepted when pix_valid & pix_ready
//  pix_y        in   5   luma sample
//  pix_c        in   5   chroma sample (Cb/Cr interleave is the packer's job)
//  pix_sof      in   1   marks first pixel of a frame
//  tx_sym       out  6   registered link symbol
//  tx_frame_odd out  1   1 while an FRAME1 frame is in flight
//  busy         out  1   state != IDLE
//  underrun     out  1   sticky: payload slot with no pixel; cleared only by reset
//  sof_err      out  1   sticky: pix_sof missing on pixel 0, or set on any other pixel
// BEHAVIOUR
//  Reset is asynchronous on rstn (active low); clock is clk. Reset values: tx_sym=6'h00,
//  pix_ready=0, tx_frame_odd=0, busy=0, underrun=0, sof_err=0. Internal state: IDLE,
//  parity=1 (first frame after reset is FRAME1), counters=0.
//  States:
//  - IDLE: tx_sym=00. Goes to FHDR when en=1.
//  - FHDR: 4 cycles; sends the header selected by parity. tx_frame_odd=parity for the whole frame.
//  - LHDR: 2 cycles, 6'h15 each.
//  - PAY: 2*LINE_PIX cycles. Even slot: pix_ready=1 (combinational, PAY even slots only).
//    - On transfer: tx_sym<={0,pix_y}, latch pix_c. Odd slot: tx_sym<={1,c_latched}.
//    - No pix_valid in an even slot: tx_sym<=6'h3F. Set underrun. Repeat the even slot; the
//      pixel is never skipped and the line is stretched.
//  - LGAP: LINE_GAP cycles of 00. Then LHDR if line<LINES-1, else FGAP.
//  - FGAP: FRAME_GAP cycles of 00. Toggle parity. Then FHDR if en=1, else IDLE.
//  Latency: a pixel accepted at edge N appears as Y on tx_sym after edge N and as C after edge N+1.
//  Frame length with no underrun: 4 + LINES*(2 + 2*LINE_PIX + LINE_GAP) + FRAME_GAP cycles.
//  en deasserted mid-frame: has no effect until the end of FGAP, so frames are never truncated.
//  Counters: pixel counter 0..LINE_PIX-1 and line counter 0..LINES-1 wrap to 0 at line/frame end.
//  sof_err: checked on every transfer against (line==0 && pix==0). Checking only; data path
//    unaffected.
//  Sync hazard: payload symbols may alias header codes. The receiver decodes by position, so no
//    escaping is done.
//  Simultaneous transfer and underrun: impossible by construction (only one event per even slot).
//  rstn asserted mid-frame: immediate return to IDLE with reset values. The next frame restarts
//    with FRAME1.
// TESTING
//  1 Reset, en=1, pix_valid=1 constant -> tx_sym 2A,2B,05,15, then 15,15, then {0,y0},{1,c0}...;
//    pix_ready pulses every 2nd PAY cycle.
//  2 Two full frames (LINE_PIX=4, LINES=2, gaps 1/2) -> second header 2A,28,35,15;
//    tx_frame_odd 1 then 0; frame length 4+2*(2+8+1)+2=28 cycles.
//  3 Drop pix_valid for 3 cycles mid-line -> three 6'h3F symbols, underrun=1 sticky;
//    Y/C order and pixel count unchanged.
//  4 pix_sof on pixel 1 only -> sof_err=1; symbol stream identical to test 1.
//  5 en=0 during line 1 -> frame completes through FGAP, then IDLE with tx_sym=00 and busy=0.
//  6 rstn low during PAY -> outputs at reset values immediately; on release with en=1 the header
//    is FRAME1 again.

Source files
------------

// File: rtl/slant_lane_tx.sv
// slant_lane_tx: frames a 5-bit Y/C pixel stream into 6-bit slant link symbols for one lane
module slant_lane_tx #(
    parameter logic [23:0] FRAME1    = 24'haab155,
    parameter logic [23:0] FRAME0    = 24'haa8d55,
    parameter logic [7:0]  HSYNC     = 8'h55,
    parameter int          LINE_PIX  = 160,
    parameter int          LINES     = 240,
    parameter int          LINE_GAP  = 4,
    parameter int          FRAME_GAP = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [4:0] pix_y,
    input  logic [4:0] pix_c,
    input  logic       pix_sof,
    output logic [5:0] tx_sym,
    output logic       tx_frame_odd,
    output logic       busy,
    output logic       underrun,
    output logic       sof_err
);
    localparam int CMAX = (FRAME_GAP > LINE_GAP) ? ((FRAME_GAP > 4) ? FRAME_GAP : 4)
                                                 : ((LINE_GAP > 4) ? LINE_GAP : 4);
    localparam int CW = $clog2(CMAX + 1);
    localparam int PW = $clog2(LINE_PIX + 1);
    localparam int LW = $clog2(LINES + 1);

    typedef enum logic [2:0] {IDLE, FHDR, LHDR, PAY, LGAP, FGAP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] pix_q;
    logic [LW-1:0] line_q;
    logic          half_q;
    logic          parity_q;
    logic [4:0]    c_q;
    logic [5:0]    sym_q;
    logic          odd_q;
    logic          und_q;
    logic          sof_q;
    logic [23:0]   hdr;
    logic [5:0]    hdr_sym;

    // Header word for the current parity, sliced MSB-first by the header symbol counter
    always_comb begin
        hdr     = parity_q ? FRAME1 : FRAME0;
        hdr_sym = (cnt_q[1:0] == 2'd0) ? hdr[23:18] :
                  (cnt_q[1:0] == 2'd1) ? hdr[17:12] :
                  (cnt_q[1:0] == 2'd2) ? hdr[11:6]  : hdr[5:0];
    end

    assign pix_ready    = (state_q == PAY) && !half_q;
    assign busy         = (state_q != IDLE);
    assign tx_sym       = sym_q;
    assign tx_frame_odd = odd_q;
    assign underrun     = und_q;
    assign sof_err      = sof_q;

    // Framing FSM: every symbol is registered, so the stream lags the state by one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pix_q    <= '0;
            line_q   <= '0;
            half_q   <= 1'b0;
            parity_q <= 1'b1;
            c_q      <= '0;
            sym_q    <= '0;
            odd_q    <= 1'b0;
            und_q    <= 1'b0;
            sof_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sym_q <= '0;
                    if (en) begin
                        state_q <= FHDR;
                        cnt_q   <= '0;
                        odd_q   <= parity_q;
                    end
                end
                FHDR: begin
                    sym_q <= hdr_sym;
                    cnt_q <= (cnt_q == CW'(3)) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CW'(3)) state_q <= LHDR;
                end
                LHDR: begin
                    sym_q <= HSYNC[5:0];
                    cnt_q <= (cnt_q == CW'(1)) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= PAY;
                        pix_q   <= '0;
                        half_q  <= 1'b0;
                    end
                end
                PAY: begin
                    if (!half_q) begin
                        if (pix_valid) begin
                            sym_q  <= {1'b0, pix_y};
                            c_q    <= pix_c;
                            half_q <= 1'b1;
                            if (pix_sof != (line_q == '0 && pix_q == '0)) sof_q <= 1'b1;
                        end else begin
                            sym_q <= 6'h3F;
                            und_q <= 1'b1;
                        end
                    end else begin
                        sym_q  <= {1'b1, c_q};
                        half_q <= 1'b0;
                        pix_q  <= (pix_q == PW'(LINE_PIX - 1)) ? '0 : pix_q + 1'b1;
                        if (pix_q == PW'(LINE_PIX - 1)) begin
                            state_q <= LGAP;
                            cnt_q   <= '0;
                        end
                    end
                end
                LGAP: begin
                    sym_q <= '0;
                    cnt_q <= (cnt_q == CW'(LINE_GAP - 1)) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CW'(LINE_GAP - 1)) begin
                        state_q <= (line_q == LW'(LINES - 1)) ? FGAP : LHDR;
                        line_q  <= (line_q == LW'(LINES - 1)) ? '0 : line_q + 1'b1;
                    end
                end
                FGAP: begin
                    sym_q <= '0;
                    cnt_q <= (cnt_q == CW'(FRAME_GAP - 1)) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CW'(FRAME_GAP - 1)) begin
                        parity_q <= ~parity_q;
                        state_q  <= en ? FHDR : IDLE;
                        odd_q    <= en ? ~parity_q : 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slant_lane_tx.sv
// tb_slant_lane_tx: randomized directed bench for slant_lane_tx against a frame-level stream model
module tb_slant_lane_tx;
    localparam int LP = 4;
    localparam int LN = 2;
    localparam int LG = 1;
    localparam int FG = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [4:0] pix_y = '0;
    logic [4:0] pix_c = '0;
    logic       pix_ready;
    logic [5:0] tx_sym;
    logic       tx_frame_odd;
    logic       busy;
    logic       underrun;
    logic       sof_err;

    int checks = 0;
    int errors = 0;
    bit exp_und = 1'b0;
    bit exp_sof = 1'b0;

    slant_lane_tx #(.LINE_PIX(LP), .LINES(LN), .LINE_GAP(LG), .FRAME_GAP(FG)) dut (
        .clk(clk), .rstn(rstn), .en(en), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_y(pix_y), .pix_c(pix_c), .pix_sof(pix_sof), .tx_sym(tx_sym),
        .tx_frame_odd(tx_frame_odd), .busy(busy), .underrun(underrun), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_sym", tx_sym, 6'h00);
        chk("rst_ready", 6'(pix_ready), 6'd0);
        chk("rst_odd", 6'(tx_frame_odd), 6'd0);
        chk("rst_busy", 6'(busy), 6'd0);
        chk("rst_und", 6'(underrun), 6'd0);
        chk("rst_sof", 6'(sof_err), 6'd0);
    endtask

    // Expected stream of one frame, starting with the DUT already in its header:
    // 4 header symbols, then per line 2 sync symbols, Y/C pairs (3F for every empty
    // even slot), line gap; frame gap last. en is changed at the start of line 1.
    task automatic run_frame(input bit odd, input int drop_pct, input int forced,
                             input bit sof_bad, input bit en_next);
        logic [23:0] hdr;
        logic [5:0]  hs;
        logic [4:0]  y;
        logic [4:0]  c;
        bit          v;
        bit          sof;
        int          drops;
        hdr = odd ? 24'haab155 : 24'haa8d55;
        for (int k = 0; k < 4; k++) begin
            pix_valid = 1'($urandom);
            step();
            hs = hdr[23 - 6*k -: 6];
            chk("hdr", tx_sym, hs);
            chk("frame_odd", 6'(tx_frame_odd), 6'(odd));
            chk("busy", 6'(busy), 6'd1);
        end
        for (int l = 0; l < LN; l++) begin
            if (l == 1) en = en_next;
            for (int k = 0; k < 2; k++) begin
                step();
                chk("hsync", tx_sym, 6'h15);
            end
            for (int p = 0; p < LP; p++) begin
                y = 5'($urandom);
                c = 5'($urandom);
                drops = (l == 0 && p == 2) ? forced : 0;
                sof = sof_bad ? (l == 0 && p == 1) : (l == 0 && p == 0);
                for (int guard = 0; guard < 64; guard++) begin
                    v = (drops > 0) ? 1'b0 : ($urandom_range(0, 99) >= drop_pct);
                    if (drops > 0) drops--;
                    if (guard == 63) v = 1'b1;
                    pix_valid = v;
                    pix_y = v ? y : 5'($urandom);
                    pix_c = v ? c : 5'($urandom);
                    pix_sof = sof;
                    chk("ready_even", 6'(pix_ready), 6'd1);
                    step();
                    if (v) begin
                        chk("pay_y", tx_sym, {1'b0, y});
                        if (sof != (l == 0 && p == 0)) exp_sof = 1'b1;
                        break;
                    end
                    chk("pay_gap", tx_sym, 6'h3F);
                    exp_und = 1'b1;
                end
                pix_valid = 1'($urandom);
                pix_y = 5'($urandom);
                pix_c = 5'($urandom);
                pix_sof = 1'($urandom);
                chk("ready_odd", 6'(pix_ready), 6'd0);
                step();
                chk("pay_c", tx_sym, {1'b1, c});
                chk("underrun", 6'(underrun), 6'(exp_und));
                chk("sof_err", 6'(sof_err), 6'(exp_sof));
            end
            for (int k = 0; k < LG; k++) begin
                step();
                chk("lgap", tx_sym, 6'h00);
            end
        end
        for (int k = 0; k < FG; k++) begin
            step();
            chk("fgap", tx_sym, 6'h00);
        end
        chk("busy_end", 6'(busy), 6'(en_next));
    endtask

    initial begin
        int n;
        #12;
        chk_reset();
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("idle_busy", 6'(busy), 6'd0);
        en = 1'b1;
        step();
        chk("idle_sym", tx_sym, 6'h00);
        chk("start_busy", 6'(busy), 6'd1);
        run_frame(1'b1, 0, 0, 1'b0, 1'b1);
        run_frame(1'b0, 0, 0, 1'b0, 1'b1);
        run_frame(1'b1, 0, 3, 1'b0, 1'b1);
        run_frame(1'b0, 0, 0, 1'b1, 1'b1);
        run_frame(1'b1, 20, 0, 1'b0, 1'b0);
        step();
        chk("stop_sym", tx_sym, 6'h00);
        chk("stop_busy", 6'(busy), 6'd0);
        chk("stop_odd", 6'(tx_frame_odd), 6'd0);
        en = 1'b1;
        pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < 40) begin
            step();
            n++;
        end
        chk("reach_pay", 6'(pix_ready), 6'd1);
        step();
        rstn = 1'b0;
        #1;
        exp_und = 1'b0;
        exp_sof = 1'b0;
        chk_reset();
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("restart_sym", tx_sym, 6'h00);
        run_frame(1'b1, 10, 0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
